// File: rtl/spi_rx.sv
// spi_rx: SPI peripheral-side receiver (MSB first, sample on data_clk rise,
// active-low sel). Synchronises the three SPI pins into clk_in and shifts in
// DATA_WIDTH-bit words.
//
// Ports:
//   clk_in          system clock, rising edge
//   rst_in          synchronous active-low reset
//   data_in         serial data pin (async)
//   data_clk_in     SPI clock pin (async)
//   sel_in          chip select pin (async, active-low)
//   data_out        last completed word, MSB = first bit received
//   data_valid_out  one-cycle strobe, data_out is new this cycle
//   busy_out        high while a frame is active
//   frame_error_out one-cycle strobe, sel rose with a partial word pending
module spi_rx #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  data_in,
  input  logic                  data_clk_in,
  input  logic                  sel_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid_out,
  output logic                  busy_out,
  output logic                  frame_error_out
);

  localparam int unsigned CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [SYNC_STAGES-1:0]  sclk_sync_q, sel_sync_q, din_sync_q;
  logic                    sclk_prev_q, sel_prev_q;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    valid_q, valid_d;
  logic                    busy_q, busy_d;
  logic                    ferr_q, ferr_d;

  logic sclk_s, sel_s, din_s;
  logic sclk_rise, sel_fall, sel_rise;

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign sel_s  = sel_sync_q[SYNC_STAGES-1];
  assign din_s  = din_sync_q[SYNC_STAGES-1];

  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sel_fall  = ~sel_s & sel_prev_q;
  assign sel_rise  = sel_s & ~sel_prev_q;

  // Synchronisers, edge history and all state; reset drives everything idle.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      sclk_sync_q <= '0;
      sel_sync_q  <= '1;
      din_sync_q  <= '0;
      sclk_prev_q <= 1'b0;
      sel_prev_q  <= 1'b1;
      state_q     <= ST_IDLE;
      shift_q     <= '0;
      cnt_q       <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      ferr_q      <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], data_clk_in};
      sel_sync_q  <= {sel_sync_q[SYNC_STAGES-2:0], sel_in};
      din_sync_q  <= {din_sync_q[SYNC_STAGES-2:0], data_in};
      sclk_prev_q <= sclk_s;
      sel_prev_q  <= sel_s;
      state_q     <= state_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
      ferr_q      <= ferr_d;
    end
  end

  // Frame FSM and shift datapath. sel edges take priority over a coincident
  // sclk rise, so that rise is dropped on frame entry and exit.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    valid_d = 1'b0;
    busy_d  = busy_q;
    ferr_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sel_fall) begin
          state_d = ST_ACTIVE;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (sel_rise) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          ferr_d  = (cnt_q != '0);
          cnt_d   = '0;
        end else if (sclk_rise) begin
          shift_d = {shift_q[DATA_WIDTH-2:0], din_s};
          if (cnt_q == LAST_BIT) begin
            data_d  = {shift_q[DATA_WIDTH-2:0], din_s};
            valid_d = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign data_out        = data_q;
  assign data_valid_out  = valid_q;
  assign busy_out        = busy_q;
  assign frame_error_out = ferr_q;

endmodule

// File: doc/spi_rx.md
Name: spi_rx

Overview:
- SPI peripheral-side receiver; the other end of the team's spi_tx link (MSB first, data sampled on data_clk rising edge, sel active-low).
- Synchronises the three asynchronous SPI pins into the clk_in domain and shifts in DATA_WIDTH-bit words.
- Presents each completed word with a one-cycle valid strobe.
- Flags frames where sel deasserts before a word completes.

Parameters:
- DATA_WIDTH, 8, bits per word; must be >= 2.
- SYNC_STAGES, 2, flip-flop depth of each input synchroniser; must be >= 2.

Ports:
- clk_in  input  1  system clock; all logic on its rising edge.
- rst_in  input  1  synchronous, active-low reset.
- data_in  input  1  serial data pin (asynchronous to clk_in).
- data_clk_in  input  1  SPI clock pin (asynchronous); data is valid at its rising edge.
- sel_in  input  1  chip select pin (asynchronous), active-low.
- data_out  output  DATA_WIDTH  last completed word, MSB = first bit received.
- data_valid_out  output  1  one-cycle strobe; data_out is new this cycle.
- busy_out  output  1  high while a frame is active (synchronised sel low).
- frame_error_out  output  1  one-cycle strobe; sel rose with 1..DATA_WIDTH-1 bits pending.

Behaviour:
- Reset (rst_in == 0 at a clk_in edge) sets every synchroniser flop to idle:
  - data_clk syncs -> 0; sel syncs -> 1; data syncs -> 0.
  - Edge-history regs -> 0 for data_clk, 1 for sel.
  - shift reg and bit counter -> 0.
  - data_out -> 0, data_valid_out -> 0, busy_out -> 0, frame_error_out -> 0.
- Reset mid-frame discards partial bits; no strobes are emitted for that frame.
- Synchronisation:
  - Each pin passes through SYNC_STAGES flops.
  - sclk_s, sel_s and din_s are the final-stage outputs.
  - A registered copy of sclk_s and of sel_s provides edge detection.
  - sclk_rise = sclk_s & ~sclk_prev.
  - sel_fall = ~sel_s & sel_prev; sel_rise = sel_s & ~sel_prev.
- States:
  - IDLE (sel_s high).
  - ACTIVE (sel_s low).
- IDLE -> ACTIVE on sel_fall:
  - bit counter <= 0; busy_out <= 1 on the same edge the transition registers.
  - An sclk_rise in the sel_fall cycle is ignored.
- ACTIVE, on sclk_rise:
  - shift <= {shift[DATA_WIDTH-2:0], din_s}; counter <= counter + 1.
  - When the counter equals DATA_WIDTH-1 at the sample:
    - data_out <= {shift[DATA_WIDTH-2:0], din_s}; data_valid_out <= 1 on that same edge (pulse lasts exactly one cycle).
    - counter <= 0.
  - Back-to-back words within one frame are supported; the next sclk_rise starts word 2.
- ACTIVE -> IDLE on sel_rise:
  - busy_out <= 0.
  - If the counter != 0, frame_error_out pulses 1 cycle, the counter clears and data_out is unchanged.
  - If the counter == 0, no error.
  - An sclk_rise coinciding with sel_rise is ignored.
- sclk edges while IDLE are ignored; shift and counter are held.
- data_out holds its value until the next completed word.
- Latency: data_valid_out rises exactly SYNC_STAGES+1 clk_in cycles after the pin-level rising edge of the final data_clk. This assumes the pin was stable across the sampling edge.
- Input timing requirements:
  - data_clk high and low phases must each be >= SYNC_STAGES+1 clk_in cycles.
  - data_in must be stable from one cycle before the sclk rise until SYNC_STAGES+1 cycles after.
  - The spi_tx default DATA_PERIOD=100 satisfies both. Faster input is unsupported; there is no error flag for it.

Test Plan:
- Loopback with spi_tx (DATA_WIDTH=8, DATA_PERIOD=100), send 8'hA5 -> exactly one data_valid_out pulse, data_out=8'hA5, busy_out high for the frame then low, no frame_error_out.
- Directed pin drive: 16 sclk rises within one sel-low window carrying 8'h3C then 8'hF0 -> two valid pulses with data_out 8'h3C then 8'hF0; busy_out stays high between them.
- Abort: sel low, 5 sclk rises, sel high -> frame_error_out single pulse 3 cycles after the sel pin rise, no valid pulse, data_out keeps the prior value; the next full frame 8'h81 is received correctly.
- sclk toggled 10 times with sel high, then a normal frame 8'h01 -> no strobes during idle toggles, data_out=8'h01 afterwards.
- Reset (rst_in=0 for 1 cycle) after 4 bits of a frame, sel released and then re-asserted -> all outputs 0 after reset, no error pulse; a fresh frame 8'h7E yields data_out=8'h7E.
- Latency check: log the clk_in cycle of the 8th sclk pin rise and the data_valid_out assertion -> difference is exactly SYNC_STAGES+1 (3 at default); repeat with SYNC_STAGES=3 -> 4.
